// File: rtl/fetch_buffer.sv
// Instruction fetch stage: owns the fetch PC, issues reads to a 1-cycle synchronous ROM,
// and queues {pc, instr} pairs in a small FIFO drained by decode; redirects flush everything.
module fetch_buffer #(
   parameter int unsigned      WIDTH    = 32,
   parameter int unsigned      DEPTH    = 4,
   parameter logic [WIDTH-1:0] RESET_PC = 32'hBFC00000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       redirect,
   input  logic [WIDTH-1:0]           redirect_pc,
   output logic                       imem_req,
   output logic [WIDTH-1:0]           imem_addr,
   input  logic [31:0]                imem_rdata,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [31:0]                out_instr,
   output logic [WIDTH-1:0]           out_pc,
   output logic [$clog2(DEPTH):0]     occupancy
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W:0]   DEPTH_V   = (CNT_W + 1)'(DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

   typedef struct packed {
      logic [WIDTH-1:0] pc;
      logic [31:0]      instr;
   } entry_t;

   entry_t           mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_next;
   logic [CNT_W:0]   pending;
   logic [WIDTH-1:0] fetch_pc;
   logic [WIDTH-1:0] inflight_pc;
   logic [WIDTH-1:0] target_pc;
   logic             inflight;
   logic             credit_ok;
   logic             push;
   logic             pop;

   // A read is only issued when the FIFO still has room for its response,
   // counting the one that may already be in flight, so a push can never overflow.
   always_comb begin
      pending   = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
      credit_ok = (pending < DEPTH_V);
      imem_req  = !rst && !redirect && credit_ok;
      push      = inflight && !redirect;
      pop       = out_valid && out_ready;
      target_pc = redirect_pc & ~WIDTH'(3);
   end

   // NOTE: every always_comb output is given a default first so no latch is inferred.
   always_comb begin
      count_next = count;
      if (redirect) begin
         count_next = '0;
      end else if (push && !pop) begin
         count_next = count + CNT_W'(1);
      end else if (pop && !push) begin
         count_next = count - CNT_W'(1);
      end
   end

   assign imem_addr = fetch_pc;
   assign out_valid = (count != '0);
   assign occupancy = count;
   assign out_pc    = mem[rd_ptr].pc;
   assign out_instr = mem[rd_ptr].instr;

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the values that were present before the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
         count       <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         // NOTE: the storage is reset too, because the head fields are visible
         // on the outputs and must read as zero after reset.
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
      end else begin
         count    <= count_next;
         inflight <= imem_req;
         if (imem_req) begin
            inflight_pc <= fetch_pc;
            fetch_pc    <= fetch_pc + WIDTH'(4);
         end
         if (redirect) begin
            // The response returning now belongs to the old path and is dropped.
            fetch_pc <= target_pc;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
         end else begin
            if (push) begin
               mem[wr_ptr] <= '{pc: inflight_pc, instr: imem_rdata};
               wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + PTR_W'(1);
            end
         end
      end
   end

   a_no_overflow : assert property (@(posedge clk) disable iff (rst) count <= DEPTH_CNT);

   a_head_stable : assert property (@(posedge clk) disable iff (rst)
      (out_valid && !out_ready && !redirect) |=> ($stable(out_pc) && $stable(out_instr)));

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: streaming, backpressure, redirects, async reset, PC wrap.
// A behavioural ROM returns each word equal to its own address.
module tb_fetch_buffer;

   logic        clk;
   logic        rst;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [2:0]  occupancy;

   logic        rst_b;
   logic        redirect_b;
   logic [31:0] redirect_pc_b;
   logic        imem_req_b;
   logic [31:0] imem_addr_b;
   logic [31:0] imem_rdata_b;
   logic        out_valid_b;
   logic        out_ready_b;
   logic [31:0] out_instr_b;
   logic [31:0] out_pc_b;
   logic [2:0]  occupancy_b;

   int n_checks = 0;
   int n_fail   = 0;

   fetch_buffer #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'hBFC00000)) u_dut (
      .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_pc(out_pc), .occupancy(occupancy)
   );

   fetch_buffer #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'hFFFFFFF8)) u_dut_wrap (
      .clk(clk), .rst(rst_b), .redirect(redirect_b), .redirect_pc(redirect_pc_b),
      .imem_req(imem_req_b), .imem_addr(imem_addr_b), .imem_rdata(imem_rdata_b),
      .out_valid(out_valid_b), .out_ready(out_ready_b), .out_instr(out_instr_b),
      .out_pc(out_pc_b), .occupancy(occupancy_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (imem_req)   imem_rdata   <= imem_addr;
      if (imem_req_b) imem_rdata_b <= imem_addr_b;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   logic [31:0] exp_pc;

   initial begin
      rst = 1'b1; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b1;
      rst_b = 1'b1; redirect_b = 1'b0; redirect_pc_b = '0; out_ready_b = 1'b1;
      tick(); tick(); #1;
      check("rst_valid", 32'(out_valid), 0);
      check("rst_req",   32'(imem_req), 0);
      check("rst_occ",   32'(occupancy), 0);
      check("rst_pc",    out_pc, 0);
      check("rst_instr", out_instr, 0);
      check("rst_addr",  imem_addr, 32'hBFC00000);

      // Streaming with decode always ready
      tick(); rst = 1'b0; #1;
      check("t1_req_c0",   32'(imem_req), 1);
      check("t1_addr_c0",  imem_addr, 32'hBFC00000);
      check("t1_valid_c0", 32'(out_valid), 0);
      tick(); #1;
      check("t1_valid_c1", 32'(out_valid), 0);
      check("t1_addr_c1",  imem_addr, 32'hBFC00004);
      for (int k = 0; k < 6; k++) begin
         tick(); #1;
         check("t1_valid", 32'(out_valid), 1);
         check("t1_pc",    out_pc, 32'hBFC00000 + 32'(4 * k));
         check("t1_instr", out_instr, 32'hBFC00000 + 32'(4 * k));
      end

      // Backpressure from the start: four issues, then stall
      tick(); rst = 1'b1; out_ready = 1'b0;
      tick(); rst = 1'b0; #1;
      check("t2_req_c0", 32'(imem_req), 1);
      for (int c = 1; c < 4; c++) begin
         tick(); #1;
         check("t2_req", 32'(imem_req), 1);
      end
      tick(); #1;
      check("t2_req_c4", 32'(imem_req), 0);
      check("t2_occ_c4", 32'(occupancy), 3);
      tick(); #1;
      check("t2_req_c5",   32'(imem_req), 0);
      check("t2_occ_full", 32'(occupancy), 4);
      for (int c = 0; c < 3; c++) begin
         tick(); #1;
         check("t2_hold_pc",    out_pc, 32'hBFC00000);
         check("t2_hold_instr", out_instr, 32'hBFC00000);
         check("t2_hold_req",   32'(imem_req), 0);
      end
      exp_pc = 32'hBFC00000;
      tick(); out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         #1;
         check("t2_valid", 32'(out_valid), 1);
         check("t2_pc",    out_pc, exp_pc);
         exp_pc = exp_pc + 32'd4;
         tick();
      end

      // Redirect with FIFO at credit limit and a fetch in flight
      rst = 1'b1; out_ready = 1'b0;
      tick(); rst = 1'b0;
      for (int c = 0; c < 4; c++) tick();
      redirect = 1'b1; redirect_pc = 32'hBFC00103; #1;
      check("t3_req_n",  32'(imem_req), 0);
      check("t3_occ_n",  32'(occupancy), 3);
      tick(); redirect = 1'b0; #1;
      check("t3_valid_n1", 32'(out_valid), 0);
      check("t3_occ_n1",   32'(occupancy), 0);
      check("t3_req_n1",   32'(imem_req), 1);
      check("t3_addr_n1",  imem_addr, 32'hBFC00100);
      tick(); #1;
      check("t3_valid_n2", 32'(out_valid), 0);
      check("t3_addr_n2",  imem_addr, 32'hBFC00104);
      tick(); out_ready = 1'b1; #1;
      check("t3_valid_n3", 32'(out_valid), 1);
      check("t3_pc_n3",    out_pc, 32'hBFC00100);
      check("t3_instr_n3", out_instr, 32'hBFC00100);
      tick(); #1;
      check("t3_pc_n4", out_pc, 32'hBFC00104);
      tick(); #1;
      check("t3_pc_n5", out_pc, 32'hBFC00108);

      // Redirect while the head is being accepted
      redirect = 1'b1; redirect_pc = 32'hBFC00200; #1;
      check("t4_valid_n", 32'(out_valid), 1);
      check("t4_req_n",   32'(imem_req), 0);
      tick(); redirect = 1'b0; #1;
      check("t4_valid_n1", 32'(out_valid), 0);
      check("t4_occ_n1",   32'(occupancy), 0);
      check("t4_addr_n1",  imem_addr, 32'hBFC00200);
      tick(); #1;
      check("t4_valid_n2", 32'(out_valid), 0);
      for (int k = 0; k < 3; k++) begin
         tick(); #1;
         check("t4_valid", 32'(out_valid), 1);
         check("t4_pc",    out_pc, 32'hBFC00200 + 32'(4 * k));
      end

      // Asynchronous reset between clock edges
      tick(); #2; rst = 1'b1; #1;
      check("t5_valid_async", 32'(out_valid), 0);
      check("t5_req_async",   32'(imem_req), 0);
      check("t5_occ_async",   32'(occupancy), 0);
      check("t5_pc_async",    out_pc, 0);
      tick(); rst = 1'b0; #1;
      check("t5_req_c0",  32'(imem_req), 1);
      check("t5_addr_c0", imem_addr, 32'hBFC00000);
      tick(); #1;
      check("t5_valid_c1", 32'(out_valid), 0);
      check("t5_occ_c1",   32'(occupancy), 0);
      tick(); #1;
      check("t5_valid_c2", 32'(out_valid), 1);
      check("t5_pc_c2",    out_pc, 32'hBFC00000);

      // PC wrap-around from the top of the address space
      check("t6_rst_addr",  imem_addr_b, 32'hFFFFFFF8);
      check("t6_rst_valid", 32'(out_valid_b), 0);
      tick(); rst_b = 1'b0;
      tick(); tick(); #1;
      exp_pc = 32'hFFFFFFF8;
      for (int k = 0; k < 4; k++) begin
         check("t6_valid", 32'(out_valid_b), 1);
         check("t6_pc",    out_pc_b, exp_pc);
         check("t6_instr", out_instr_b, exp_pc);
         exp_pc = exp_pc + 32'd4;
         tick(); #1;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
